// File: rtl/bythoven_pkg.sv
// Constants shared by the instruction fetch stage and the note player decoder.
package bythoven_pkg;

    localparam int INS_W = 16;
    localparam int ADDR_W = 18;
    localparam logic [INS_W-1:0] HALT_WORD = 16'hFFFF;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and a clear that wins over push/pop.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic w_full;
    logic w_empty;
    logic w_wr_en;
    logic w_rd_en;

    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_wr_en = i_push && !w_full;
    assign w_rd_en = i_pop && !w_empty;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage is not reset; the head is masked to zero while empty instead.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_valid = !w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

// File: rtl/ins_fetch.sv
// Instruction prefetch: sequential async-SRAM reads into a small FIFO, stopping at the halt word.
module ins_fetch #(
    parameter int                              ADDR_W      = bythoven_pkg::ADDR_W,
    parameter int                              DEPTH       = 4,
    parameter int                              WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0]               START_ADDR  = '0,
    parameter logic [ADDR_W-1:0]               END_ADDR    = '1,
    parameter logic [bythoven_pkg::INS_W-1:0]  HALT_WORD   = bythoven_pkg::HALT_WORD
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              restart,
    output logic [ADDR_W-1:0]                 SRAM_A,
    output logic                              SRAM_CE,
    output logic                              SRAM_OE,
    output logic                              SRAM_LB,
    output logic                              SRAM_UB,
    output logic                              SRAM_WE,
    input  logic [bythoven_pkg::INS_W-1:0]    SRAM_D,
    output logic [bythoven_pkg::INS_W-1:0]    ins_data,
    output logic                              ins_valid,
    input  logic                              ins_ready,
    output logic                              halted,
    output logic [$clog2(DEPTH):0]            level
);

    import bythoven_pkg::*;

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_sram_a;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_halted;

    logic              w_space;
    logic              w_capture;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;
    logic [INS_W-1:0]  w_head;
    logic [LVL_W-1:0]  w_level;

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return (pc == END_ADDR) ? START_ADDR : pc + 1'b1;
    endfunction

    assign w_space   = (w_level < LVL_W'(DEPTH));
    assign w_capture = (r_state == FS_WAIT) && (r_cnt == '0);
    // A restart in the capture cycle discards the in-flight word.
    assign w_push    = w_capture && !restart;
    assign w_pop     = w_valid && ins_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= FS_IDLE;
            r_pc     <= START_ADDR;
            r_sram_a <= START_ADDR;
            r_cnt    <= '0;
            r_halted <= 1'b0;
        end else if (restart) begin
            r_state  <= FS_IDLE;
            r_pc     <= START_ADDR;
            r_cnt    <= '0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                FS_IDLE: begin
                    if (w_space) begin
                        r_sram_a <= r_pc;
                        r_cnt    <= CNT_W'(WAIT_CYCLES - 1);
                        r_state  <= FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_pc <= next_pc(r_pc);
                        if (SRAM_D == HALT_WORD) begin
                            r_state  <= FS_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= FS_IDLE;
                        end
                    end
                end
                FS_HALT: begin
                    r_state <= FS_HALT;
                end
                default: begin
                    r_state <= FS_IDLE;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (INS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .i_clr   (restart),
        .i_push  (w_push),
        .i_data  (SRAM_D),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_valid (w_valid),
        .o_level (w_level)
    );

    assign SRAM_A    = r_sram_a;
    assign SRAM_CE   = 1'b0;
    assign SRAM_OE   = 1'b0;
    assign SRAM_LB   = 1'b0;
    assign SRAM_UB   = 1'b0;
    assign SRAM_WE   = 1'b1;
    assign ins_data  = w_head;
    assign ins_valid = w_valid;
    assign halted    = r_halted;
    assign level     = w_level;

endmodule

// File: doc/ins_fetch.md
# ins_fetch

Instruction prefetch stage for the note player. Reads 16-bit instruction words from the external asynchronous SRAM, starting at `START_ADDR` and reading sequentially. Each word is pushed into a small FIFO. The player pops one word per beat with a valid/ready handshake. Fetch stops after `HALT_WORD` is read, and a `restart` pulse rewinds to the start.

## Interface
- `ADDR_W`, 18: SRAM address width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `WAIT_CYCLES`, 2: cycles SRAM_A is held before SRAM_D is sampled; ≥1.
- `START_ADDR`, 0: first fetch address; also the wrap target.
- `END_ADDR`, 2^ADDR_W−1: last address before wrap.
- `HALT_WORD`, 16'hFFFF: end-of-program marker.

Ports:
- `CLK` in 1: 50 MHz clock; the only clock.
- `RST` in 1: synchronous, active-high reset.
- `restart` in 1: single-cycle pulse; rewind fetch and flush the FIFO.
- `SRAM_A` out ADDR_W: registered read address.
- `SRAM_CE`, `SRAM_OE`, `SRAM_LB`, `SRAM_UB` out 1: held at constant 0.
- `SRAM_WE` out 1: held at constant 1 (read-only).
- `SRAM_D` in 16: read data.
- `ins_data` out 16: FIFO head word.
- `ins_valid` out 1: FIFO non-empty.
- `ins_ready` in 1: consumer accepts the head word.
- `halted` out 1: `HALT_WORD` has been fetched.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
The FSM has three states: IDLE, WAIT, HALT.
- **IDLE**
  - If `level < DEPTH`: `SRAM_A <= pc`, load the wait counter with WAIT_CYCLES−1, go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT**
  - When the counter is nonzero, decrement it.
  - When the counter is 0:
    - capture `SRAM_D` and push it into the FIFO;
    - `pc <= (pc == END_ADDR) ? START_ADDR : pc+1`;
    - if the captured word is `HALT_WORD`, go to HALT and set `halted`; otherwise go to IDLE.
  - The push always succeeds, because only one read is in flight and occupancy was checked at launch.
- **HALT**: no further reads. `SRAM_A` holds its last address. The FIFO keeps draining.
- **HALT_WORD**: pushed into the FIFO like any other word, so the consumer sees the end of program.
- **Pop**: occurs when `ins_valid && ins_ready`. A simultaneous push and pop leaves `level` unchanged and preserves FIFO order.
- **Priority**: RST > restart > normal operation.
- **restart**: next cycle the FIFO is empty, `pc = START_ADDR`, `halted = 0`, state is IDLE. Any in-flight read is discarded and never pushed.
- **RST mid-operation**: same effect as restart, plus all outputs take their reset values.
- **Reset values**:
  - `SRAM_A = START_ADDR`, `pc = START_ADDR`;
  - `ins_valid = 0`, `ins_data = 0`, `level = 0`, `halted = 0`;
  - SRAM control pins at their constant levels.

## Timing
- Cycle 0 is the first cycle with RST low. The FSM is in IDLE and registers `SRAM_A`.
- `SRAM_A` is valid during cycles 1 … WAIT_CYCLES.
- `SRAM_D` is sampled at the edge ending cycle WAIT_CYCLES.
- `ins_valid` rises in cycle WAIT_CYCLES+1. Fetch-to-valid latency is WAIT_CYCLES+1 cycles.
- Sustained rate is one word per WAIT_CYCLES+1 cycles (3 with defaults), far faster than one beat.
- A pop frees a slot in the next cycle. With a full FIFO in IDLE, a new fetch launches on the cycle after the pop.
- `ins_data` is stable while `ins_valid && !ins_ready`.

## Structure
- Shared package `bythoven_pkg`: `INS_W=16`, `ADDR_W=18`, `HALT_WORD`, fetch FSM state enum. The player decodes against the same constants.
- Sub-module `sync_fifo`: parameterised width and depth, push/pop, `level`, synchronous clear. `restart` drives the clear.
- Everything else lives in the top FSM: wait counter, pc, address register.

## Test plan
- **Basic fetch**: SRAM model holds 0x0013 at 0 and 0x0025 at 1; `ins_ready = 1` → `ins_valid` rises in cycle 3 with data 0x0013; next word 0x0025 is valid in cycle 6.
- **Backpressure**: `ins_ready = 0` → addresses 0–3 are fetched, `level = 4`, `SRAM_A` stays at 3. One pop → fetch of address 4 launches next cycle; `level` returns to 4.
- **Halt**: `HALT_WORD` at address 2 → three words pushed, the last being 0xFFFF; `halted = 1`; no further `SRAM_A` changes; `halted` stays high while the FIFO drains.
- **Restart mid-WAIT**: pulse `restart` during an in-flight read → next cycle `level = 0` and `halted = 0`; the discarded word never appears; fetch restarts at 0.
- **Wrap**: `END_ADDR = 3`, no halt word present → `SRAM_A` sequence 0,1,2,3,0,1.
- **Simultaneous push and pop**: pop in the capture cycle with `level = 1` → `level` stays 1; words emerge in address order.
